// File: rtl/posit_opgroup_dispatcher_if.sv
// Issue / result bus of the posit op-group dispatcher.
// master = dispatcher side, slave = ops source, lanes and result sink.
interface posit_opgroup_dispatcher_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 4
);
    logic                   flush_i;
    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [3:0]             op_i;
    logic [3*WIDTH-1:0]     operands_i;
    logic [2:0]             rnd_mode_i;
    logic [TAG_W-1:0]       tag_i;
    logic [2:0]             lane_valid_o;
    logic [2:0]             lane_ready_i;
    logic [3:0]             lane_op_o;
    logic [3*WIDTH-1:0]     lane_operands_o;
    logic [2:0]             lane_rnd_o;
    logic [TAG_W-1:0]       lane_tag_o;
    logic [2:0]             lane_res_valid_i;
    logic [2:0]             lane_res_ready_o;
    logic [3*WIDTH-1:0]     lane_result_i;
    logic [14:0]            lane_status_i;
    logic [3*TAG_W-1:0]     lane_tag_i;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [WIDTH-1:0]       result_o;
    logic [4:0]             status_o;
    logic [TAG_W-1:0]       tag_o;
    logic                   busy_o;

    modport master (
        input  flush_i, in_valid_i, op_i, operands_i,
        input  rnd_mode_i, tag_i, lane_ready_i,
        input  lane_res_valid_i, lane_result_i,
        input  lane_status_i, lane_tag_i, out_ready_i,
        output in_ready_o, lane_valid_o, lane_op_o,
        output lane_operands_o, lane_rnd_o, lane_tag_o,
        output lane_res_ready_o, out_valid_o, result_o,
        output status_o, tag_o, busy_o
    );

    modport slave (
        output flush_i, in_valid_i, op_i, operands_i,
        output rnd_mode_i, tag_i, lane_ready_i,
        output lane_res_valid_i, lane_result_i,
        output lane_status_i, lane_tag_i, out_ready_i,
        input  in_ready_o, lane_valid_o, lane_op_o,
        input  lane_operands_o, lane_rnd_o, lane_tag_o,
        input  lane_res_ready_o, out_valid_o, result_o,
        input  status_o, tag_o, busy_o
    );
endinterface

// File: rtl/posit_opgroup_dispatcher.sv
// Posit op-group dispatcher: decodes ops to ADDMUL/DIVSQRT/NONCOMP lanes,
// bounds in-flight ops per lane, answers illegal ops with NaR/NV, and
// round-robin merges lane results into one registered output.
// Ports: clk_i, rst_ni (async active-low), bus (issue, lane, result side).
module posit_opgroup_dispatcher #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned TAG_W     = 4,
    parameter int unsigned MAX_OUTST = 4
) (
    input logic                        clk_i,
    input logic                        rst_ni,
    posit_opgroup_dispatcher_if.master bus
);
    localparam int unsigned CW = $clog2(MAX_OUTST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTST);
    localparam logic [WIDTH-1:0] POSIT_NAR = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [4:0] ST_NV = 5'b10000;

    typedef enum logic [3:0] {
        FMADD, FNMSUB, ADD, MUL, DIV,
        SQRT, SGNJ, MINMAX, CMP, CLASSIFY
    } operation_e;

    typedef enum logic [1:0] {
        ADDMUL  = 2'd0,
        DIVSQRT = 2'd1,
        NONCOMP = 2'd2
    } opgroup_e;

    function automatic opgroup_e get_opgroup(input logic [3:0] op);
        if (op <= 4'(MUL)) return ADDMUL;
        if (op <= 4'(SQRT)) return DIVSQRT;
        return NONCOMP;
    endfunction

    logic [2:0][CW-1:0] cnt_q, cnt_d;
    logic [1:0]         ptr_q, ptr_d;
    logic               err_valid_q, err_valid_d;
    logic [TAG_W-1:0]   err_tag_q, err_tag_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [4:0]         status_q, status_d;
    logic [TAG_W-1:0]   tag_q, tag_d;

    logic       op_legal;
    logic [1:0] grp;
    logic [2:0] room, lane_valid, inc, dec, res_ready, underflow;
    logic       in_ready, err_push, err_pop, load_en;
    logic [3:0] req, grant;
    logic [1:0] gidx, arb_idx;

    // rnd_mode 3'b110 and DYN (3'b111) are both rejected
    assign op_legal = (bus.op_i <= 4'(CLASSIFY)) &&
                      (bus.rnd_mode_i[2:1] != 2'b11);
    assign grp = get_opgroup(bus.op_i);

    for (genvar l = 0; l < 3; l++) begin : g_room
        assign room[l] = cnt_q[l] < CNT_MAX;
    end

    always_comb begin
        lane_valid = '0;
        in_ready   = 1'b0;
        err_push   = 1'b0;
        if (!bus.flush_i) begin
            if (op_legal) begin
                lane_valid[grp] = bus.in_valid_i & room[grp];
                in_ready        = bus.lane_ready_i[grp] & room[grp];
            end else begin
                in_ready = ~err_valid_q;
                err_push = bus.in_valid_i & ~err_valid_q;
            end
        end
    end

    assign req     = {err_valid_q, bus.lane_res_valid_i};
    assign load_en = ~out_valid_q | bus.out_ready_i;

    // first requester at or after the pointer wins
    always_comb begin
        grant   = '0;
        gidx    = '0;
        arb_idx = '0;
        for (int k = 0; k < 4; k++) begin
            arb_idx = ptr_q + 2'(k);
            if (grant == '0 && req[arb_idx]) begin
                grant[arb_idx] = 1'b1;
                gidx           = arb_idx;
            end
        end
    end

    // during flush every lane result is drained and dropped
    assign res_ready = bus.flush_i ? 3'b111 :
                       ({3{load_en}} & grant[2:0]);
    assign err_pop   = ~bus.flush_i & load_en & grant[3];
    assign inc       = lane_valid & bus.lane_ready_i;
    assign dec       = bus.lane_res_valid_i & res_ready;

    always_comb begin
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        err_valid_d = err_valid_q;
        err_tag_d   = err_tag_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        status_d    = status_q;
        tag_d       = tag_q;
        underflow   = '0;
        for (int l = 0; l < 3; l++) begin
            underflow[l] = dec[l] & ~bus.flush_i & (cnt_q[l] == '0);
            if (inc[l] && !dec[l]) begin
                cnt_d[l] = cnt_q[l] + CW'(1);
            end else if (dec[l] && !inc[l] && cnt_q[l] != '0) begin
                cnt_d[l] = cnt_q[l] - CW'(1);
            end
        end
        if (err_pop) err_valid_d = 1'b0;
        if (err_push) begin
            err_valid_d = 1'b1;
            err_tag_d   = bus.tag_i;
        end
        if (load_en) begin
            out_valid_d = |req;
            if (|req) begin
                ptr_d = gidx + 2'd1;
                if (grant[3]) begin
                    result_d = POSIT_NAR;
                    status_d = ST_NV;
                    tag_d    = err_tag_q;
                end else begin
                    result_d = bus.lane_result_i[int'(gidx)*WIDTH +: WIDTH];
                    status_d = bus.lane_status_i[int'(gidx)*5 +: 5];
                    tag_d    = bus.lane_tag_i[int'(gidx)*TAG_W +: TAG_W];
                end
            end
        end
        if (bus.flush_i) begin
            cnt_d       = '0;
            ptr_d       = '0;
            err_valid_d = 1'b0;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q       <= '0;
            ptr_q       <= '0;
            err_valid_q <= 1'b0;
            err_tag_q   <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            status_q    <= '0;
            tag_q       <= '0;
        end else begin
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            err_valid_q <= err_valid_d;
            err_tag_q   <= err_tag_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            status_q    <= status_d;
            tag_q       <= tag_d;
        end
    end

    a_no_underflow: assert property (
        @(posedge clk_i) disable iff (!rst_ni) underflow == 3'b000
    );

    assign bus.in_ready_o       = in_ready;
    assign bus.lane_valid_o     = lane_valid;
    assign bus.lane_op_o        = bus.op_i;
    assign bus.lane_operands_o  = bus.operands_i;
    assign bus.lane_rnd_o       = bus.rnd_mode_i;
    assign bus.lane_tag_o       = bus.tag_i;
    assign bus.lane_res_ready_o = res_ready;
    assign bus.out_valid_o      = out_valid_q;
    assign bus.result_o         = result_q;
    assign bus.status_o         = status_q;
    assign bus.tag_o            = tag_q;
    assign bus.busy_o = (cnt_q != '0) | err_valid_q | out_valid_q;
endmodule

// File: tb/tb_posit_opgroup_dispatcher.sv
// Bench for posit_opgroup_dispatcher: decode table, directed
// corner sequences and a randomized run against a queue model.
module tb_posit_opgroup_dispatcher;
    localparam int W  = 32;
    localparam int TW = 4;
    localparam int MO = 4;
    localparam logic [31:0] NAR = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    posit_opgroup_dispatcher_if #(.WIDTH(W), .TAG_W(TW)) bus ();

    posit_opgroup_dispatcher #(
        .WIDTH(W), .TAG_W(TW), .MAX_OUTST(MO)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [95:0] act,
                       input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush_i          = 1'b0;
        bus.in_valid_i       = 1'b0;
        bus.op_i             = '0;
        bus.operands_i       = '0;
        bus.rnd_mode_i       = '0;
        bus.tag_i            = '0;
        bus.lane_ready_i     = '0;
        bus.lane_res_valid_i = '0;
        bus.lane_result_i    = '0;
        bus.lane_status_i    = '0;
        bus.lane_tag_i       = '0;
        bus.out_ready_i      = 1'b0;
    endtask

    task automatic do_flush();
        idle();
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [3:0] tg);
        bus.in_valid_i = 1'b1;
        bus.op_i       = op;
        bus.tag_i      = tg;
        #1;
        chk("issue_ready", bus.in_ready_o, 1'b1);
        tick();
        bus.in_valid_i = 1'b0;
    endtask

    task automatic chk_out(input string nm, input logic [31:0] r,
                           input logic [4:0] s, input logic [3:0] t);
        chk({nm, "_v"}, bus.out_valid_o, 1'b1);
        chk({nm, "_res"}, bus.result_o, r);
        chk({nm, "_st"}, bus.status_o, s);
        chk({nm, "_tag"}, bus.tag_o, t);
    endtask

    task automatic wait_out(input string nm);
        int n = 0;
        while (!bus.out_valid_o && n < 4) begin
            tick();
            n++;
        end
        chk({nm, "_timeout"}, bus.out_valid_o, 1'b1);
    endtask

    typedef struct {
        logic [3:0] op;
        logic [2:0] rnd;
        logic [2:0] lv;
        logic       rdy;
    } dec_vec_t;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  st;
        logic [3:0]  tag;
    } item_t;

    item_t      lq[3][$];
    logic [2:0] pres = '0;
    logic       err_full = 1'b0;
    logic [3:0] err_tag = '0;
    item_t      held = '0;
    logic       held_v = 1'b0;

    task automatic rand_cycle(input bit drain);
        logic [3:0] op, tg;
        logic [2:0] rnd, lr, exp_lv, rr, rv, hs;
        logic       fl, iv, legal, exp_ir, ld, ok, ecap, got_v;
        int         g;
        item_t      got, it;
        fl  = !drain && ($urandom_range(0, 99) == 0);
        iv  = !drain && ($urandom_range(0, 1) == 1);
        op  = ($urandom_range(0, 99) < 85) ?
              4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
        rnd = ($urandom_range(0, 19) == 0) ?
              3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
        tg  = 4'($urandom);
        lr  = 3'($urandom);
        bus.flush_i      = fl;
        bus.in_valid_i   = iv;
        bus.op_i         = op;
        bus.rnd_mode_i   = rnd;
        bus.tag_i        = tg;
        bus.operands_i   = {$urandom, $urandom, $urandom};
        bus.lane_ready_i = lr;
        bus.out_ready_i  = drain || ($urandom_range(0, 3) != 0);
        for (int l = 0; l < 3; l++) begin
            if (!pres[l] && lq[l].size() > 0 && $urandom_range(0, 2) != 0)
                pres[l] = 1'b1;
            bus.lane_res_valid_i[l] = pres[l];
            it = pres[l] ? lq[l][0] : '0;
            bus.lane_result_i[l*32 +: 32] = it.res;
            bus.lane_status_i[l*5 +: 5]   = it.st;
            bus.lane_tag_i[l*4 +: 4]      = it.tag;
        end
        #1;
        legal  = (op <= 4'd9) && (rnd < 3'd6);
        g      = (op < 4'd4) ? 0 : (op < 4'd6) ? 1 : 2;
        exp_lv = '0;
        exp_ir = 1'b0;
        if (!fl) begin
            if (legal) begin
                exp_lv[g] = iv && (lq[g].size() < MO);
                exp_ir    = lr[g] && (lq[g].size() < MO);
            end else begin
                exp_ir = !err_full;
            end
        end
        chk("r_lane_valid", bus.lane_valid_o, exp_lv);
        chk("r_in_ready", bus.in_ready_o, exp_ir);
        chk("r_lane_tag", bus.lane_tag_o, tg);
        chk("r_lane_opnd", bus.lane_operands_o, bus.operands_i);
        rr = bus.lane_res_ready_o;
        rv = bus.lane_res_valid_i;
        ld = !bus.out_valid_o || bus.out_ready_i;
        if (fl) begin
            chk("r_flush_rr", rr, 3'b111);
        end else begin
            ok = ($countones(rr) <= 1) && ((rr & ~rv) == 0) &&
                 (ld || rr == 0) &&
                 (!(ld && rv != 0 && rr == 0) || err_full);
            chk("r_res_ready_rule", {rr, ok}, {rr, 1'b1});
        end
        hs   = rr & rv;
        ecap = !fl && iv && !legal && !err_full;
        tick();
        if (fl) begin
            for (int l = 0; l < 3; l++) lq[l].delete();
            pres     = '0;
            err_full = 1'b0;
            held_v   = 1'b0;
        end else begin
            if ((exp_lv & lr) != 0)
                lq[g].push_back({$urandom, 5'($urandom), tg});
            got_v = 1'b0;
            got   = '0;
            for (int l = 0; l < 3; l++) begin
                if (hs[l]) begin
                    got     = lq[l].pop_front();
                    pres[l] = 1'b0;
                    got_v   = 1'b1;
                end
            end
            if (ld) begin
                if (got_v) begin
                    held   = got;
                    held_v = 1'b1;
                end else if (err_full) begin
                    held     = {NAR, 5'b10000, err_tag};
                    held_v   = 1'b1;
                    err_full = 1'b0;
                end else begin
                    held_v = 1'b0;
                end
            end
            if (ecap) begin
                err_full = 1'b1;
                err_tag  = tg;
            end
        end
        chk("r_out_valid", bus.out_valid_o, held_v);
        if (held_v)
            chk("r_out_data",
                {bus.result_o, bus.status_o, bus.tag_o}, held);
        chk("r_busy", bus.busy_o,
            (lq[0].size() + lq[1].size() + lq[2].size() > 0) ||
            err_full || held_v);
    endtask

    dec_vec_t dv[12];
    int       rem[3];
    int       src;
    int       n;
    logic [2:0] lrr;
    logic [31:0] exp_r;

    initial begin
        dv[0]  = '{4'd0,  3'd0, 3'b001, 1'b1};
        dv[1]  = '{4'd2,  3'd0, 3'b001, 1'b1};
        dv[2]  = '{4'd3,  3'd4, 3'b001, 1'b1};
        dv[3]  = '{4'd4,  3'd1, 3'b010, 1'b0};
        dv[4]  = '{4'd5,  3'd2, 3'b010, 1'b0};
        dv[5]  = '{4'd6,  3'd3, 3'b100, 1'b1};
        dv[6]  = '{4'd9,  3'd5, 3'b100, 1'b1};
        dv[7]  = '{4'd10, 3'd0, 3'b000, 1'b1};
        dv[8]  = '{4'd15, 3'd0, 3'b000, 1'b1};
        dv[9]  = '{4'd2,  3'd6, 3'b000, 1'b1};
        dv[10] = '{4'd4,  3'd7, 3'b000, 1'b1};
        dv[11] = '{4'd8,  3'd4, 3'b100, 1'b1};

        idle();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", bus.out_valid_o, 1'b0);
        chk("rst_result", bus.result_o, 32'h0);
        chk("rst_status", bus.status_o, 5'h0);
        chk("rst_tag", bus.tag_o, 4'h0);
        chk("rst_busy", bus.busy_o, 1'b0);
        #10 rst_n = 1'b1;
        tick();

        // decode table; lane1 not ready so DIV/SQRT see in_ready=0
        bus.lane_ready_i = 3'b101;
        foreach (dv[i]) begin
            bus.in_valid_i = 1'b1;
            bus.op_i       = dv[i].op;
            bus.rnd_mode_i = dv[i].rnd;
            #1;
            chk($sformatf("dec%0d_lv", i), bus.lane_valid_o, dv[i].lv);
            chk($sformatf("dec%0d_rdy", i), bus.in_ready_o, dv[i].rdy);
            bus.in_valid_i = 1'b0;
            tick();
        end

        // ADD to lane0, result one cycle later
        idle();
        bus.out_ready_i  = 1'b1;
        bus.in_valid_i   = 1'b1;
        bus.op_i         = 4'd2;
        bus.tag_i        = 4'd3;
        bus.operands_i   = {32'h1, 32'h4000_0000, 32'h3800_0000};
        bus.lane_ready_i = 3'b001;
        #1;
        chk("t1_lane_valid", bus.lane_valid_o, 3'b001);
        chk("t1_in_ready", bus.in_ready_o, 1'b1);
        chk("t1_bc_tag", bus.lane_tag_o, 4'd3);
        chk("t1_bc_op", bus.lane_op_o, 4'd2);
        chk("t1_bc_opnd", bus.lane_operands_o, bus.operands_i);
        tick();
        bus.in_valid_i       = 1'b0;
        bus.lane_res_valid_i = 3'b001;
        bus.lane_result_i    = {64'h0, 32'h4000_0000};
        bus.lane_tag_i       = 12'h003;
        #1;
        chk("t1_res_ready", bus.lane_res_ready_o, 3'b001);
        tick();
        bus.lane_res_valid_i = '0;
        chk_out("t1_out", 32'h4000_0000, 5'b0, 4'd3);
        tick();
        chk("t1_idle_valid", bus.out_valid_o, 1'b0);
        chk("t1_idle_busy", bus.busy_o, 1'b0);

        // lane1 fills to MAX_OUTST then stalls until a result returns
        do_flush();
        bus.lane_ready_i = 3'b010;
        bus.out_ready_i  = 1'b1;
        for (int i = 0; i < MO; i++) issue(4'd4, 4'(i));
        bus.in_valid_i = 1'b1;
        bus.tag_i      = 4'd4;
        #1;
        chk("t2_full_ready", bus.in_ready_o, 1'b0);
        chk("t2_full_lv", bus.lane_valid_o, 3'b000);
        tick();
        bus.lane_res_valid_i = 3'b010;
        bus.lane_result_i    = {32'h0, 32'h1234_5678, 32'h0};
        #1;
        chk("t2_res_rr", bus.lane_res_ready_o, 3'b010);
        chk("t2_same_cyc", bus.in_ready_o, 1'b0);
        tick();
        bus.lane_res_valid_i = '0;
        #1;
        chk("t2_freed_ready", bus.in_ready_o, 1'b1);
        chk("t2_freed_lv", bus.lane_valid_o, 3'b010);
        chk_out("t2_out", 32'h1234_5678, 5'b0, 4'd0);
        tick();

        // illegal op and illegal rounding mode
        do_flush();
        bus.out_ready_i  = 1'b1;
        bus.lane_ready_i = 3'b111;
        bus.in_valid_i   = 1'b1;
        bus.op_i         = 4'hC;
        bus.tag_i        = 4'd7;
        #1;
        chk("t3_no_lane", bus.lane_valid_o, 3'b000);
        chk("t3_ready", bus.in_ready_o, 1'b1);
        tick();
        bus.in_valid_i = 1'b0;
        wait_out("t3a");
        chk_out("t3a", NAR, 5'b10000, 4'd7);
        tick();
        bus.in_valid_i = 1'b1;
        bus.op_i       = 4'd2;
        bus.rnd_mode_i = 3'b110;
        bus.tag_i      = 4'd9;
        #1;
        chk("t3b_no_lane", bus.lane_valid_o, 3'b000);
        tick();
        bus.in_valid_i = 1'b0;
        bus.rnd_mode_i = 3'b000;
        wait_out("t3b");
        chk_out("t3b", NAR, 5'b10000, 4'd9);
        tick();

        // all four sources busy: round-robin 0,1,2,3,0,1,2,3
        do_flush();
        bus.out_ready_i  = 1'b1;
        bus.lane_ready_i = 3'b111;
        issue(4'd2, 4'd0);
        issue(4'd2, 4'd1);
        issue(4'd4, 4'd2);
        issue(4'd4, 4'd3);
        issue(4'd6, 4'd4);
        issue(4'd6, 4'd5);
        issue(4'hC, 4'hF);
        bus.in_valid_i = 1'b1;
        bus.op_i       = 4'hC;
        bus.tag_i      = 4'hF;
        rem = '{2, 2, 2};
        for (int i = 0; i < 8; i++) begin
            for (int l = 0; l < 3; l++) begin
                bus.lane_res_valid_i[l] = rem[l] > 0;
                bus.lane_result_i[l*32 +: 32] = 32'(l + 1) << 28;
            end
            #1;
            lrr = bus.lane_res_ready_o;
            tick();
            for (int l = 0; l < 3; l++) if (lrr[l]) rem[l]--;
            src   = i % 4;
            exp_r = (src < 3) ? (32'(src + 1) << 28) : NAR;
            chk($sformatf("t4_rr%0d_v", i), bus.out_valid_o, 1'b1);
            chk($sformatf("t4_rr%0d_src", i), bus.result_o, exp_r);
        end
        idle();
        bus.out_ready_i = 1'b1;
        tick();
        chk("t4_drained", bus.busy_o, 1'b0);

        // backpressure: output holds, no lane result taken
        do_flush();
        bus.lane_ready_i = 3'b001;
        issue(4'd3, 4'd1);
        issue(4'd3, 4'd2);
        bus.lane_res_valid_i = 3'b001;
        bus.lane_result_i    = {64'h0, 32'hAAAA_0001};
        bus.lane_tag_i       = 12'h001;
        #1;
        chk("t5_first_rr", bus.lane_res_ready_o, 3'b001);
        tick();
        bus.lane_result_i = {64'h0, 32'hBBBB_0002};
        bus.lane_tag_i    = 12'h002;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("t5_hold%0d_rr", i), bus.lane_res_ready_o, 3'b000);
            chk_out($sformatf("t5_hold%0d", i), 32'hAAAA_0001, 5'b0, 4'd1);
            tick();
        end
        bus.out_ready_i = 1'b1;
        #1;
        chk("t5_release_rr", bus.lane_res_ready_o, 3'b001);
        tick();
        bus.lane_res_valid_i = '0;
        chk_out("t5_second", 32'hBBBB_0002, 5'b0, 4'd2);
        tick();
        chk("t5_empty", bus.out_valid_o, 1'b0);

        // flush with lanes holding {2,1,1} and a valid output
        do_flush();
        bus.lane_ready_i = 3'b111;
        issue(4'd2, 4'd1);
        issue(4'd2, 4'd2);
        issue(4'd2, 4'd3);
        issue(4'd4, 4'd4);
        issue(4'd6, 4'd5);
        bus.lane_res_valid_i = 3'b001;
        tick();
        chk("t6_pre_valid", bus.out_valid_o, 1'b1);
        bus.flush_i          = 1'b1;
        bus.in_valid_i       = 1'b1;
        bus.op_i             = 4'd2;
        bus.lane_res_valid_i = 3'b111;
        #1;
        chk("t6_flush_rr", bus.lane_res_ready_o, 3'b111);
        chk("t6_flush_ready", bus.in_ready_o, 1'b0);
        chk("t6_flush_lv", bus.lane_valid_o, 3'b000);
        tick();
        idle();
        #1;
        chk("t6_post_valid", bus.out_valid_o, 1'b0);
        chk("t6_post_busy", bus.busy_o, 1'b0);

        // asynchronous reset in the middle of traffic
        bus.lane_ready_i = 3'b001;
        issue(4'd2, 4'd6);
        bus.lane_res_valid_i = 3'b001;
        bus.lane_result_i    = {64'h0, 32'h5555_AAAA};
        bus.lane_tag_i       = 12'h006;
        bus.lane_status_i    = 15'h0001;
        tick();
        bus.lane_res_valid_i = '0;
        bus.in_valid_i       = 1'b1;
        tick();
        chk("t6_burst_busy", bus.busy_o, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", bus.out_valid_o, 1'b0);
        chk("arst_result", bus.result_o, 32'h0);
        chk("arst_status", bus.status_o, 5'h0);
        chk("arst_tag", bus.tag_o, 4'h0);
        chk("arst_busy", bus.busy_o, 1'b0);
        idle();
        #2 rst_n = 1'b1;
        tick();

        for (int i = 0; i < 3000; i++) rand_cycle(1'b0);
        n = 0;
        while ((lq[0].size() + lq[1].size() + lq[2].size() > 0 ||
                err_full || held_v) && n < 300) begin
            rand_cycle(1'b1);
            n++;
        end
        chk("drain_done", held_v || err_full, 1'b0);
        chk("drain_busy", bus.busy_o, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
